// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package stopwatch_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;

  localparam logic [2:0] SLOT_CS = 3'd0;
  localparam logic [2:0] SLOT_DS = 3'd1;
  localparam logic [2:0] SLOT_SU = 3'd2;
  localparam logic [2:0] SLOT_ST = 3'd3;
  localparam logic [2:0] SLOT_MU = 3'd4;
  localparam logic [2:0] SLOT_MT = 3'd5;

  localparam logic [5:0] DP_MASK = 6'b010100;

endpackage

// File: rtl/stopwatch_display_scan_seg7_decode.sv
// BCD to 7-segment decoder, active-high outputs.
// Codes 10..15 fall back to the '0' pattern.
module seg7_decode
  import stopwatch_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/stopwatch_display_scan.sv
// Six-digit multiplexed 7-segment scan with frame snapshot and freeze.
// Optional STOPWATCH_LEADING_ZERO_BLANK_EN blanks leading minute zeros.
module stopwatch_display_scan
  import stopwatch_pkg::*;
#(
  parameter int SCAN_DIV       = 50_000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       hard_reset,
  input  logic [3:0] d,
  input  logic [3:0] e,
  input  logic [3:0] f,
  input  logic [3:0] g,
  input  logic [3:0] h,
  input  logic [3:0] i,
  input  logic       freeze,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam int PW = $clog2(SCAN_DIV);

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [NUM_DIGITS-1:0][3:0] snap;
  logic          tick;
  logic [3:0]    digit;
  logic [6:0]    seg_dec;
  logic          blank;
  logic          lit;
  logic [6:0]    seg_r;
  logic          dp_r;
  logic [5:0]    an_r;

  assign tick = (presc == PW'(SCAN_DIV - 1));

  always_comb begin
    digit = 4'd0;
    case (idx)
      SLOT_CS: digit = snap[0];
      SLOT_DS: digit = snap[1];
      SLOT_SU: digit = snap[2];
      SLOT_ST: digit = snap[3];
      SLOT_MU: digit = snap[4];
      SLOT_MT: digit = snap[5];
      default: digit = 4'd0;
    endcase
  end

  seg7_decode u_dec (
    .digit (digit),
    .seg   (seg_dec)
  );

`ifdef STOPWATCH_LEADING_ZERO_BLANK_EN
  assign blank = ((idx == SLOT_MT) && (snap[5] == 4'd0))
              || ((idx == SLOT_MU) && (snap[5] == 4'd0)
                  && (snap[4] == 4'd0));
`else
  assign blank = 1'b0;
`endif

  assign lit = ~blank;

  always_ff @(posedge clk or negedge hard_reset) begin
    if (!hard_reset) begin
      presc <= '0;
      idx   <= SLOT_CS;
      snap  <= '0;
      seg_r <= '0;
      dp_r  <= 1'b0;
      an_r  <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick)
        idx <= (idx == SLOT_MT) ? SLOT_CS : idx + 3'd1;
      // Load at the frame boundary so all six digits agree.
      if (tick && (idx == SLOT_MT) && !freeze)
        snap <= {i, h, g, f, e, d};
      seg_r <= lit ? seg_dec : 7'd0;
      dp_r  <= lit & DP_MASK[idx];
      an_r  <= lit ? (6'd1 << idx) : 6'd0;
    end
  end

  assign seg = SEG_ACTIVE_LOW ? ~seg_r : seg_r;
  assign dp  = SEG_ACTIVE_LOW ? ~dp_r  : dp_r;
  assign an  = AN_ACTIVE_LOW  ? ~an_r  : an_r;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Bench for stopwatch_display_scan: directed steps plus random
// digits/freeze/reset against a frame-level display model.
module tb_stopwatch_display_scan;

  localparam int DIV   = 4;
  localparam int FRAME = 6 * DIV;

  logic       clk = 1'b0;
  logic       hard_reset = 1'b0;
  logic [3:0] d, e, f, g, h, i;
  logic       freeze = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [3:0] msnap [6];

  stopwatch_display_scan #(
    .SCAN_DIV       (DIV),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .hard_reset (hard_reset),
    .d          (d),
    .e          (e),
    .f          (f),
    .g          (g),
    .h          (h),
    .i          (i),
    .freeze     (freeze),
    .seg        (seg),
    .dp         (dp),
    .an         (an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input logic [3:0] v);
    case (v)
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [6:0] es,
                       input logic ed, input logic [5:0] ea);
    n_cmp++;
    assert ({seg, dp, an} === {es, ed, ea}) else begin
      n_bad++;
      $error("FAIL %s @cyc %0d: observed seg=%b dp=%b an=%b expected seg=%b dp=%b an=%b",
             tag, cyc, seg, dp, an, es, ed, ea);
    end
  endtask

  task automatic set_in(input logic [3:0] a0, input logic [3:0] a1,
                        input logic [3:0] a2, input logic [3:0] a3,
                        input logic [3:0] a4, input logic [3:0] a5);
    d = a0; e = a1; f = a2; g = a3; h = a4; i = a5;
  endtask

  // One clock: display depends on the slot for this cycle and the
  // snapshot taken at the previous frame boundary.
  task automatic step(input string tag);
    int slot;
    bit lit;
    logic [6:0] es;
    logic ed;
    logic [5:0] ea;
    @(posedge clk);
    slot = (cyc / DIV) % 6;
    lit = 1'b1;
`ifdef STOPWATCH_LEADING_ZERO_BLANK_EN
    if (slot == 5 && msnap[5] == 4'd0) lit = 1'b0;
    if (slot == 4 && msnap[5] == 4'd0 && msnap[4] == 4'd0) lit = 1'b0;
`endif
    es = lit ? ~pat(msnap[slot]) : 7'h7f;
    ed = (lit && (slot == 2 || slot == 4)) ? 1'b0 : 1'b1;
    ea = lit ? ~(6'd1 << slot) : 6'h3f;
    if ((cyc % FRAME) == FRAME - 1 && !freeze) begin
      msnap[0] = d; msnap[1] = e; msnap[2] = f;
      msnap[3] = g; msnap[4] = h; msnap[5] = i;
    end
    cyc++;
    #1;
    check(tag, es, ed, ea);
  endtask

  task automatic run(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  task automatic do_reset(input string tag);
    hard_reset = 1'b0;
    #2;
    check(tag, 7'h7f, 1'b1, 6'h3f);
    @(posedge clk);
    #1;
    check(tag, 7'h7f, 1'b1, 6'h3f);
    hard_reset = 1'b1;
    cyc = 0;
    for (int k = 0; k < 6; k++) msnap[k] = 4'd0;
  endtask

  initial begin
    set_in(4'd7, 4'd8, 4'd9, 4'd5, 4'd3, 4'd2);
    freeze = 1'b0;
    #1;
    do_reset("reset");

    // First cycle after release: slot 0 showing '0'.
    @(posedge clk);
    #1;
    check("first", ~7'b0111111, 1'b1, 6'b111110);
    cyc = 1;
    run("first_frame", FRAME - 1);

    set_in(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0);
    run("scan", 2 * FRAME);

    run("coh_pre", 2 * DIV + 1);
    set_in(4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4);
    run("coherence", 2 * FRAME);

    run("frz_align", 3);
    freeze = 1'b1;
    for (int k = 0; k < 3 * FRAME; k++) begin
      if (k % 5 == 0)
        set_in(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
               4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
               4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)));
      step("freeze");
    end
    freeze = 1'b0;
    run("unfreeze", 2 * FRAME);

    set_in(4'd10, 4'd1, 4'd2, 4'd6, 4'd1, 4'd1);
    run("invalid", 2 * FRAME);

    set_in(4'd5, 4'd4, 4'd3, 4'd2, 4'd0, 4'd0);
    run("lz_both", 2 * FRAME);
    h = 4'd3;
    run("lz_h3", 2 * FRAME);

    run("mid_pre", 2 * DIV + 2);
    do_reset("mid_reset");
    run("post_reset", 2 * FRAME);

    for (int k = 0; k < 900; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 5))
          0: d = 4'($urandom);
          1: e = 4'($urandom);
          2: f = 4'($urandom);
          3: g = 4'($urandom);
          4: h = 4'($urandom_range(0, 3));
          default: i = 4'($urandom_range(0, 2));
        endcase
      end
      if ($urandom_range(0, 39) == 0) freeze = ~freeze;
      if ($urandom_range(0, 299) == 0) do_reset("rand_reset");
      step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
